audio_playback_buffer: RTL and testbench
========================================

// Module: audio_playback_buffer
// PURPOSE
//  Audio sink downstream of DATA_FSM's audio path. Buffers 8-bit unsigned PCM
//  bytes from DATA_FSM (write_audio strobes) in a FIFO, requests SD bursts when
//  low, pops one sample per audio_clk_en (8 kHz) and drives a 1-bit PWM DAC.
//  Fills the audio FIFO/controller slot in badApple_top; sole clock CLK_40.
// PARAMETERS
//  SAMPLE_W     8     sample width, unsigned, midscale = 2**(SAMPLE_W-1)
//  DEPTH        1024  FIFO entries, power of two
//  AW           10    log2(DEPTH)
//  BURST        512   bytes DATA_FSM delivers per audio request (one SD block)
//  START_LEVEL  512   level needed to leave FILL; must be <= DEPTH
// PORTS
//  CLK_40           in   1        system clock, 40 MHz
//  reset            in   1        async, active-high; clears all state
//  play_en          in   1        playback enable (high after init)
//  audio_clk_en     in   1        1-cycle strobe at 8 kHz from clk_en_gen
//  write_audio      in   1        1-cycle strobe: audio_byte valid
//  audio_byte       in   SAMPLE_W sample from DATA_FSM
//  audio_data_ready in   1        1-cycle pulse: requested burst complete
//  audio_req        out  1        level request to DATA_FSM for one burst
//  pwm_out          out  1        PWM DAC output (GPIO)
//  fifo_level       out  AW+1     entries held, 0..DEPTH
//  underrun         out  1        sticky: pop attempted while empty
//  overflow         out  1        sticky: write dropped while full
// BEHAVIOUR
//  Reset: audio_req=0, pwm_out=0, fifo_level=0, underrun=0, overflow=0,
//   FSM=IDLE, rd/wr ptrs=0, cur_sample=midscale, pwm_cnt=0.
//  FIFO: wr_ptr/rd_ptr AW+1 bits, wrap via MSB; level=wr_ptr-rd_ptr.
//   Write: write_audio && level<DEPTH -> store, wr_ptr++ same edge.
//   Write at full: drop byte, set overflow. Write accepted in all states.
//   Pop: audio_clk_en && state==PLAY && level>0 -> cur_sample<=mem[rd_ptr],
//   rd_ptr++; sample visible at the PWM comparator the cycle after the strobe.
//   Pop+write same cycle: both happen; level unchanged. A pop never returns
//   a byte written in the same cycle (empty stays empty that cycle).
//  FSM:
//   IDLE: audio_req=0; cur_sample=midscale. play_en=1 -> FILL.
//   FILL: no pops. audio_req per request rule. level>=START_LEVEL -> PLAY.
//   PLAY: pops on audio_clk_en. Strobe with level==0 -> set underrun,
//    cur_sample<=midscale, -> FILL (re-prebuffer).
//   Any state: play_en=0 -> IDLE next edge, flush (rd_ptr<=wr_ptr),
//    audio_req<=0; sticky flags kept (clear only by reset).
//  Request rule (registered): audio_req rises when state in {FILL,PLAY} &&
//   level <= DEPTH-BURST && !audio_req; falls on audio_data_ready pulse.
//   audio_data_ready while audio_req=0 ignored. Hold audio_req stable while
//   a burst is in flight; never re-raise in the cycle it falls.
//  PWM: pwm_cnt SAMPLE_W-bit free-running on CLK_40 (wraps 255->0,
//   156.25 kHz carrier). pwm_out <= (pwm_cnt < cur_sample), registered.
//   sample 0 -> always 0; 255 -> high 255 of 256 cycles. cur_sample changes
//   only on pop/midscale load; no carrier resync required.
//  Reset mid-burst: all cleared asynchronously; DATA_FSM owns its own abort.
// STRUCTURE
//  Shared package badapple_pkg: SAMPLE_W, AUDIO_MIDSCALE, audio_state_t
//   enum {A_IDLE, A_FILL, A_PLAY}.
//  Sub-module audio_fifo_mem: simple dual-port DEPTH x SAMPLE_W RAM, sync
//   write, sync read (1-cycle latency, infers M10K); top holds ptrs, FSM, PWM.
//   Read address issued on pop strobe; cur_sample loads next cycle -> PWM
//   sees new sample 2 cycles after strobe (one-cycle latency allowed).
// TESTING
//  1 Reset mid-PLAY with level=300 -> all outputs at reset values next cycle,
//    level=0, audio_req=0, pwm_out=0.
//  2 play_en=1, empty -> audio_req=1 within 2 cycles; write 512 bytes
//    0x00..0xFF x2, pulse audio_data_ready -> audio_req=0, state PLAY,
//    next audio_clk_en pops 0x00, then 0x01... in order.
//  3 cur_sample=0x40 -> pwm_out high exactly 64 of every 256 cycles;
//    0x00 -> never high; 0xFF -> 255/256.
//  4 Fill to 1024, write one more -> overflow=1, level stays 1024, byte
//    dropped (read-back sequence unaffected).
//  5 PLAY, drain to 0, one more audio_clk_en -> underrun=1, pwm duty 128/256,
//    state FILL, no pop until level>=512.
//  6 write_audio and audio_clk_en same cycle at level=10 -> level stays 10;
//    at level=0 in PLAY -> underrun set, written byte retained (level=1).

Source files
------------

// File: rtl/audio_playback_buffer_pkg.sv
// Shared audio types and constants for the playback buffer slice.
package audio_playback_buffer_pkg;
  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] AUDIO_MIDSCALE = SAMPLE_W'(1 << (SAMPLE_W - 1));

  typedef enum logic [1:0] {
    A_IDLE,
    A_FILL,
    A_PLAY
  } audio_state_t;
endpackage

// File: rtl/audio_fifo_mem.sv
// Simple dual-port sample RAM: synchronous write, registered read (1-cycle latency).
module audio_fifo_mem
  import audio_playback_buffer_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                gclk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);
  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/audio_playback_buffer.sv
// Audio sink: buffers PCM bytes, requests SD bursts when low, plays out at the
// sample strobe through a PWM DAC.
module audio_playback_buffer
  import audio_playback_buffer_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int BURST       = 512,
  parameter int START_LEVEL = 512
) (
  input  logic                CLK_40,
  input  logic                reset,
  input  logic                play_en,
  input  logic                audio_clk_en,
  input  logic                write_audio,
  input  logic [SAMPLE_W-1:0] audio_byte,
  input  logic                audio_data_ready,
  output logic                audio_req,
  output logic                pwm_out,
  output logic [AW:0]         fifo_level,
  output logic                underrun,
  output logic                overflow
);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] REQ_L   = (AW+1)'(DEPTH - BURST);
  localparam logic [AW:0] START_L = (AW+1)'(START_LEVEL);

  audio_state_t        state;
  logic [AW:0]         wr_ptr, rd_ptr, level;
  logic [SAMPLE_W-1:0] rd_data, cur_sample, pwm_cnt;
  logic                wr_ok, strobe_play, pop, starve, pop_d;

  assign level       = wr_ptr - rd_ptr;
  assign fifo_level  = level;
  assign wr_ok       = write_audio && (level < DEPTH_L);
  assign strobe_play = play_en && audio_clk_en && (state == A_PLAY);
  // Level is sampled before this edge's write, so a same-cycle byte is never popped.
  assign pop         = strobe_play && (level != '0);
  assign starve      = strobe_play && (level == '0);

  audio_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .gclk  (CLK_40),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (audio_byte),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + 1'b1;
    end else if (write_audio) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state      <= A_IDLE;
      rd_ptr     <= '0;
      audio_req  <= 1'b0;
      underrun   <= 1'b0;
      cur_sample <= AUDIO_MIDSCALE;
      pop_d      <= 1'b0;
    end else if (!play_en) begin
      state      <= A_IDLE;
      rd_ptr     <= wr_ptr;
      audio_req  <= 1'b0;
      cur_sample <= AUDIO_MIDSCALE;
      pop_d      <= 1'b0;
    end else begin
      pop_d <= pop;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop_d) cur_sample <= rd_data;

      case (state)
        A_IDLE: state <= A_FILL;
        A_FILL: if (level >= START_L) state <= A_PLAY;
        A_PLAY: if (starve) begin
          state      <= A_FILL;
          underrun   <= 1'b1;
          cur_sample <= AUDIO_MIDSCALE;
        end
        default: state <= A_IDLE;
      endcase

      // Request stays up for the whole burst; the !audio_req guard keeps it low on the fall cycle.
      if (audio_req) begin
        if (audio_data_ready) audio_req <= 1'b0;
      end else if (state != A_IDLE && level <= REQ_L) begin
        audio_req <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < cur_sample);
    end
  end
endmodule

// File: tb/tb_audio_playback_buffer.sv
// Directed bench for audio_playback_buffer with a queue-based reference model.
module tb_audio_playback_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic       play_en, audio_clk_en, write_audio, audio_data_ready;
  logic [7:0] audio_byte;
  logic       audio_req, pwm_out, underrun, overflow;
  logic [10:0] fifo_level;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  audio_playback_buffer dut (
    .CLK_40          (clk),
    .reset           (rst),
    .play_en         (play_en),
    .audio_clk_en    (audio_clk_en),
    .write_audio     (write_audio),
    .audio_byte      (audio_byte),
    .audio_data_ready(audio_data_ready),
    .audio_req       (audio_req),
    .pwm_out         (pwm_out),
    .fifo_level      (fifo_level),
    .underrun        (underrun),
    .overflow        (overflow)
  );

  // Reference model: FIFO as a queue, mode as 0=idle 1=fill 2=play.
  logic [7:0] m_q[$];
  int m_mode, m_cur, m_pend, m_cnt;
  bit m_req, m_pwm, m_ovf, m_unf, m_pend_v;

  always @(posedge clk or posedge rst) begin
    int lvl, new_pend;
    bit new_pend_v, starve;
    if (rst) begin
      m_q.delete();
      m_mode = 0; m_req = 0; m_cur = 128; m_pend_v = 0; m_pend = 0;
      m_cnt = 0; m_pwm = 0; m_ovf = 0; m_unf = 0;
    end else begin
      lvl = m_q.size();
      m_pwm = (m_cnt < m_cur);
      m_cnt = (m_cnt + 1) % 256;
      if (!play_en) begin
        m_q.delete();
        if (write_audio) begin
          if (lvl < 1024) m_q.push_back(audio_byte); else m_ovf = 1;
        end
        m_mode = 0; m_req = 0; m_cur = 128; m_pend_v = 0;
      end else begin
        new_pend_v = 0; new_pend = 0; starve = 0;
        if (audio_clk_en && m_mode == 2) begin
          if (lvl > 0) begin new_pend = m_q.pop_front(); new_pend_v = 1; end
          else starve = 1;
        end
        if (write_audio) begin
          if (lvl < 1024) m_q.push_back(audio_byte); else m_ovf = 1;
        end
        if (m_pend_v) m_cur = m_pend;
        if (m_req) begin
          if (audio_data_ready) m_req = 0;
        end else if (m_mode != 0 && lvl <= 512) m_req = 1;
        if (starve) begin m_unf = 1; m_cur = 128; m_mode = 1; end
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && lvl >= 512) m_mode = 2;
        m_pend_v = new_pend_v; m_pend = new_pend;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_audio_req", audio_req, m_req);
      chk("m_pwm_out", pwm_out, m_pwm);
      chk("m_fifo_level", fifo_level, m_q.size());
      chk("m_underrun", underrun, m_unf);
      chk("m_overflow", overflow, m_ovf);
    end
  end

  task automatic cyc();
    @(negedge clk);
    write_audio = 0; audio_clk_en = 0; audio_data_ready = 0;
  endtask

  task automatic wr(input logic [7:0] v);
    audio_byte = v; write_audio = 1; cyc();
  endtask

  task automatic pop_n(input int n);
    repeat (n) begin audio_clk_en = 1; cyc(); cyc(); cyc(); end
  endtask

  task automatic duty(input int exp, input string name);
    int c = 0;
    repeat (256) begin @(negedge clk); c += int'(pwm_out); end
    chk(name, c, exp);
  endtask

  initial begin
    rst = 1; play_en = 0; audio_clk_en = 0; write_audio = 0;
    audio_data_ready = 0; audio_byte = 0;
    repeat (3) @(negedge clk);
    rst = 0; cmp_en = 1;
    chk("rst_level", fifo_level, 0);
    chk("rst_req", audio_req, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_flags", {underrun, overflow}, 0);

    // Prebuffer one burst of a ramp, then play it out.
    play_en = 1; cyc(); cyc();
    chk("req_rise", audio_req, 1);
    duty(128, "duty_mid_fill");
    for (int i = 0; i < 512; i++) wr(8'(i));
    chk("fill_level", fifo_level, 512);
    audio_data_ready = 1; cyc();
    chk("req_fall", audio_req, 0);
    pop_n(1); duty(0, "duty_00");
    pop_n(1); duty(1, "duty_01");
    pop_n(1); duty(2, "duty_02");
    pop_n(62); duty(64, "duty_40");
    pop_n(191); duty(255, "duty_ff");
    chk("level_after_256", fifo_level, 256);

    // Flush, fill to full, one dropped byte.
    play_en = 0; cyc(); play_en = 1;
    chk("flush_level", fifo_level, 0);
    for (int i = 0; i < 1024; i++) wr(8'(i + 16));
    chk("full_level", fifo_level, 1024);
    wr(8'hAA);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", fifo_level, 1024);
    pop_n(1); duty(16, "duty_first_after_ovf");
    pop_n(1023); duty(15, "duty_last_after_ovf");
    chk("drained", fifo_level, 0);

    // Strobe plus write at empty in PLAY: underrun, byte kept, back to prebuffer.
    audio_byte = 8'h5A; write_audio = 1; audio_clk_en = 1; cyc();
    chk("unf_flag", underrun, 1);
    chk("unf_level", fifo_level, 1);
    cyc(); cyc();
    duty(128, "duty_mid_unf");
    audio_clk_en = 1; cyc();
    chk("fill_no_pop", fifo_level, 1);
    for (int i = 0; i < 511; i++) wr(8'(i * 3));
    chk("refill_level", fifo_level, 512);
    cyc();
    pop_n(1); duty(90, "duty_kept_byte");
    pop_n(501);
    chk("level_10", fifo_level, 10);
    audio_byte = 8'h33; write_audio = 1; audio_clk_en = 1; cyc();
    chk("pop_wr_same", fifo_level, 10);

    // Asynchronous reset in PLAY at level 300.
    for (int i = 0; i < 290; i++) wr(8'(i));
    chk("level_300", fifo_level, 300);
    #2 rst = 1;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_req", audio_req, 0);
    chk("arst_pwm", pwm_out, 0);
    chk("arst_flags", {underrun, overflow}, 0);
    @(negedge clk); rst = 0;
    repeat (4) cyc();
    chk("post_rst_req", audio_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
